trace_checker: RTL

Synthesizable receiver for the processor's commit-trace port (`trace_val`/`trace_addr`/`trace_data`). It holds a FIFO of expected trace entries loaded before the run. It compares each committed trace beat against the FIFO head and reports pass/fail, checked and error counts, and the first mismatch. It sits beside `ProcScycle` in FPGA bring-up and self-checking benches, replacing simulation-only `check_trace` calls with hardware checking.

---
 rtl/trace_checker_pkg.sv | 30 +++
 rtl/trace_checker_fifo.sv | 54 +++++
 rtl/trace_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/trace_checker_pkg.sv
// Shared types for the commit-trace checker: state encoding, widths and the
// expected-entry record stored in the FIFO.
package trace_checker_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      TOUT = 2'd3
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              mask;
   } exp_entry_t;

   localparam int ENTRY_W = $bits(exp_entry_t);

   // A masked entry only constrains the address.
   function automatic logic entry_match(input exp_entry_t      e,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
      return (addr == e.addr) && (e.mask || (data == e.data));
   endfunction

endpackage

// File: rtl/trace_checker_fifo.sv
// Synchronous FIFO of expected trace entries with a combinational head and
// extended-pointer full/empty detection.
module trace_checker_fifo
   import trace_checker_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [ENTRY_W-1:0]         i_wdata,
   input  logic                       i_pop,
   output logic [ENTRY_W-1:0]         o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [AW:0]        r_wptr;
   logic [AW:0]        r_rptr;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_count   = r_wptr - r_rptr;
   assign o_head    = r_mem[r_rptr[AW-1:0]];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wptr[AW-1:0]] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/trace_checker.sv
// Hardware commit-trace checker: compares each trace beat against a preloaded
// FIFO of expected entries. Optional watchdog: TRACE_CHECKER_TIMEOUT_EN.
module trace_checker
   import trace_checker_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exp_val,
   output logic              exp_rdy,
   input  logic [ADDR_W-1:0] exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic              exp_mask,
   input  logic              start,
   input  logic              trace_val,
   input  logic [ADDR_W-1:0] trace_addr,
   input  logic [DATA_W-1:0] trace_data,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [15:0]       num_checked,
   output logic [15:0]       num_errors,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] err_data
);

   localparam int AW = $clog2(DEPTH);

   state_t              r_state;
   logic [15:0]         r_checked;
   logic [15:0]         r_errors;
   logic [ADDR_W-1:0]   r_err_addr;
   logic [DATA_W-1:0]   r_err_data;

   exp_entry_t          w_push_entry;
   logic [ENTRY_W-1:0]  w_head_bits;
   exp_entry_t          w_head;
   logic                w_full;
   logic                w_empty;
   logic [AW:0]         w_count;
   logic                w_push;
   logic                w_pop;
   logic                w_match;
   logic                w_last;
   logic                w_err_hit;
   logic                w_tout;

   assign w_push_entry = '{addr: exp_addr, data: exp_data, mask: exp_mask};
   assign w_head       = exp_entry_t'(w_head_bits);

   assign exp_rdy   = (r_state == LOAD) && !w_full;
   assign w_push    = exp_val && exp_rdy;
   assign w_pop     = (r_state == RUN) && trace_val;
   assign w_match   = entry_match(w_head, trace_addr, trace_data);
   assign w_last    = (w_count == {{AW{1'b0}}, 1'b1});
   // Beats after DONE have no expected entry and always count as errors.
   assign w_err_hit = trace_val &&
                      (((r_state == RUN) && !w_match) || (r_state == DONE));

   trace_checker_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_push  (w_push),
      .i_wdata (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head_bits),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

`ifdef TRACE_CHECKER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] r_wdog;

   assign w_tout = (r_state == RUN) && !trace_val && (r_wdog == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wdog <= '0;
      end else if ((r_state != RUN) || trace_val) begin
         r_wdog <= '0;
      end else begin
         r_wdog <= r_wdog + {{(WD_W-1){1'b0}}, 1'b1};
      end
   end
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT != 0);
   assign w_tout           = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= LOAD;
      end else begin
         case (r_state)
            LOAD: begin
               // A push in the start cycle counts toward the non-empty test.
               if (start) begin
                  r_state <= (!w_empty || w_push) ? RUN : DONE;
               end
            end
            RUN: begin
               if (trace_val && w_last) begin
                  r_state <= DONE;
               end else if (w_tout) begin
                  r_state <= TOUT;
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_checked  <= '0;
         r_errors   <= '0;
         r_err_addr <= '0;
         r_err_data <= '0;
      end else begin
         if (w_pop && (r_checked != '1)) begin
            r_checked <= r_checked + 16'd1;
         end
         if (w_err_hit) begin
            if (r_errors != '1) begin
               r_errors <= r_errors + 16'd1;
            end
            if (r_errors == '0) begin
               r_err_addr <= trace_addr;
               r_err_data <= trace_data;
            end
         end
      end
   end

   assign done        = (r_state == DONE) || (r_state == TOUT);
   assign pass        = (r_state == DONE) && (r_errors == '0);
   assign fail        = done && ((r_errors != '0) || (r_state == TOUT));
   assign num_checked = r_checked;
   assign num_errors  = r_errors;
   assign err_addr    = r_err_addr;
   assign err_data    = r_err_data;

endmodule
